// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith ops plus WIDTH-cycle shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module iter_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       ALUCtl,
   input  logic             Sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             div_by_zero
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;

   localparam logic [SW-1:0] CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0] CNT_LAST = {SW{1'b1}};

   logic [1:0]         state_reg;
   logic [SW-1:0]      cnt_reg;
   logic [WIDTH-1:0]   a_reg, b_reg;
   logic               sign_reg;
   logic [2*WIDTH-1:0] acc_reg, mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [WIDTH-1:0]   rem_reg, quo_reg, dvs_reg;
   logic [WIDTH-1:0]   out_reg, out_hi_reg;
   logic               dbz_reg;

   logic               accept;
   logic [SW-1:0]      shamt;
   logic               lt;
   logic [WIDTH-1:0]   sc_result;
   logic [WIDTH-1:0]   in1_mag, in2_mag;

   assign in_ready    = (state_reg == IDLE) || (state_reg == DONE && out_ready);
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_reg == DONE);
   assign out         = out_reg;
   assign out_hi      = out_hi_reg;
   assign div_by_zero = dbz_reg;

   assign shamt   = in1[SW-1:0];
   assign lt      = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
   assign in1_mag = (Sign && in1[WIDTH-1]) ? -in1 : in1;
   assign in2_mag = (Sign && in2[WIDTH-1]) ? -in2 : in2;

   always_comb begin
      sc_result = '0;
      case (ALUCtl)
         4'd0:    sc_result = in1 + in2;
         4'd1:    sc_result = in1 - in2;
         4'd4:    sc_result = in1 & in2;
         4'd5:    sc_result = in1 | in2;
         4'd6:    sc_result = in1 ^ in2;
         4'd7:    sc_result = ~(in1 | in2);
         4'd8:    sc_result = in2 << shamt;
         4'd9:    sc_result = in2 >> shamt;
         4'd10:   sc_result = $unsigned($signed(in2) >>> shamt);
         4'd11:   sc_result = {{(WIDTH-1){1'b0}}, lt};
         default: sc_result = '0;
      endcase
   end

   // Multiply step; the last step's sum goes straight through sign correction.
   logic [2*WIDTH-1:0] mul_acc, mul_prod;
   logic               mul_neg;
   assign mul_acc  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
   assign mul_neg  = sign_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
   assign mul_prod = mul_neg ? -mul_acc : mul_acc;

   // Restoring divide step: a negative trial difference keeps the shifted remainder.
   logic [WIDTH:0]     div_shift, div_trial;
   logic               div_ok;
   logic [WIDTH-1:0]   div_rem, div_quo, div_q_fix, div_r_fix;
   logic               q_neg, r_neg;
   assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, dvs_reg};
   assign div_ok    = ~div_trial[WIDTH];
   assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_quo   = {quo_reg[WIDTH-2:0], div_ok};
   assign q_neg     = sign_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
   assign r_neg     = sign_reg & a_reg[WIDTH-1];
   assign div_q_fix = q_neg ? -div_quo : div_quo;
   assign div_r_fix = r_neg ? -div_rem : div_rem;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         out_reg    <= '0;
         out_hi_reg <= '0;
         dbz_reg    <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         sign_reg   <= 1'b0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         dvs_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (accept) begin
                  a_reg      <= in1;
                  b_reg      <= in2;
                  sign_reg   <= Sign;
                  cnt_reg    <= '0;
                  acc_reg    <= '0;
                  mcand_reg  <= {{WIDTH{1'b0}}, in1_mag};
                  mplier_reg <= in2_mag;
                  rem_reg    <= '0;
                  quo_reg    <= in1_mag;
                  dvs_reg    <= in2_mag;
                  if (ALUCtl == OP_MUL) begin
                     state_reg <= MUL;
                  end else if (ALUCtl == OP_DIV) begin
                     state_reg <= DIV;
                  end else begin
                     state_reg  <= DONE;
                     out_reg    <= sc_result;
                     out_hi_reg <= '0;
                     dbz_reg    <= 1'b0;
                  end
               end else if (state_reg == DONE && out_ready) begin
                  state_reg <= IDLE;
               end
            end
            MUL: begin
               acc_reg    <= mul_acc;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + CNT_ONE;
               if (cnt_reg == CNT_LAST) begin
                  state_reg  <= DONE;
                  cnt_reg    <= '0;
                  out_reg    <= mul_prod[WIDTH-1:0];
                  out_hi_reg <= mul_prod[2*WIDTH-1:WIDTH];
                  dbz_reg    <= 1'b0;
               end
            end
            DIV: begin
               rem_reg <= div_rem;
               quo_reg <= div_quo;
               cnt_reg <= cnt_reg + CNT_ONE;
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= DONE;
                  cnt_reg   <= '0;
                  if (dvs_reg == '0) begin
                     out_reg    <= '1;
                     out_hi_reg <= a_reg;
                     dbz_reg    <= 1'b1;
                  end else begin
                     out_reg    <= div_q_fix;
                     out_hi_reg <= div_r_fix;
                     dbz_reg    <= 1'b0;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
